// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/capture stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

    // Operand/result width of the ALU that the sequencer wraps
    localparam int unsigned ALU_W = 8;

    // Opcode names; the sequencer forwards them without interpreting them
    localparam logic [1:0] OP_0 = 2'b00;
    localparam logic [1:0] OP_1 = 2'b01;
    localparam logic [1:0] OP_2 = 2'b10;
    localparam logic [1:0] OP_3 = 2'b11;

    // Sequencer control states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Registers a command onto a combinational ALU, captures f after SETTLE extra cycles, presents the result.
// Latency: accept on edge N, result captured and res_valid high from edge N+1+SETTLE.
// Backpressure: cmd_ready low outside IDLE; result held in HOLD until res_ready.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned W      = ALU_W,
    parameter int unsigned SETTLE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic [1:0]   cmd_op,
    input  logic         cmd_use_acc,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_f,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [W-1:0] acc,
    output logic         busy
);

    // Settle count is held in 4 bits, so SETTLE beyond 15 is not representable
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    seq_state_t   state_q,     state_d;
    logic [3:0]   wait_cnt_q,  wait_cnt_d;
    logic [W-1:0] alu_a_q,     alu_a_d;
    logic [W-1:0] alu_b_q,     alu_b_d;
    logic [1:0]   alu_op_q,    alu_op_d;
    logic         res_valid_q, res_valid_d;
    logic [W-1:0] res_data_q,  res_data_d;
    logic [W-1:0] acc_q,       acc_d;

    // Next-state and datapath update; every register holds unless its state says otherwise
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        acc_d       = acc_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d    = cmd_a;
                    // acc already holds the previous result here, so chained ops see it
                    alu_b_d    = cmd_use_acc ? acc_q : cmd_b;
                    alu_op_d   = cmd_op;
                    wait_cnt_d = SETTLE_CNT;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    res_data_d  = alu_f;
                    acc_d       = alu_f;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result and clears acc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 2'b00;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            acc_q       <= acc_d;
        end
    end

    // Handshake/status outputs decode the state register only, never the inputs
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU stub (add/sub/and/or).
// Two instances share stimulus: SETTLE=0 for the main scenarios, SETTLE=3 for capture timing.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd_a, cmd_b;
    logic [1:0] cmd_op;
    logic       cmd_use_acc;
    logic       res_ready;
    logic [7:0] noise3;

    logic       cmd_ready0, res_valid0, busy0;
    logic [7:0] alu_a0, alu_b0, alu_f0, res_data0, acc0;
    logic [1:0] alu_op0;

    logic       cmd_ready3, res_valid3, busy3;
    logic [7:0] alu_a3, alu_b3, alu_f3, res_data3, acc3;
    logic [1:0] alu_op3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_f0 = alu_model(alu_a0, alu_b0, alu_op0);
    assign alu_f3 = alu_model(alu_a3, alu_b3, alu_op3) ^ noise3;

    alu_op_sequencer #(.W(8), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .alu_f(alu_f0),
        .res_valid(res_valid0), .res_ready(res_ready),
        .res_data(res_data0), .acc(acc0), .busy(busy0)
    );

    alu_op_sequencer #(.W(8), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_f(alu_f3),
        .res_valid(res_valid3), .res_ready(res_ready),
        .res_data(res_data3), .acc(acc3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic use_acc);
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_op      = op;
        cmd_use_acc = use_acc;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        cmd_use_acc = 1'b0; res_ready = 1'b1; noise3 = '0;

        // Reset state
        #2;
        check("rst_cmd_ready", 8'(cmd_ready0), 8'd1);
        check("rst_res_valid", 8'(res_valid0), 8'd0);
        check("rst_busy",      8'(busy0),      8'd0);
        check("rst_alu_a",     alu_a0,         8'h00);
        check("rst_alu_b",     alu_b0,         8'h00);
        check("rst_alu_op",    8'(alu_op0),    8'h00);
        check("rst_res_data",  res_data0,      8'h00);
        check("rst_acc",       acc0,           8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // Single command, 02 + 06
        offer(8'h02, 8'h06, OP_0, 1'b0);
        tick();                       // edge N: accept
        cmd_valid = 1'b0;
        check("s1_alu_a",     alu_a0,          8'h02);
        check("s1_alu_b",     alu_b0,          8'h06);
        check("s1_busy",      8'(busy0),       8'd1);
        check("s1_cmd_ready", 8'(cmd_ready0),  8'd0);
        check("s1_vld_early", 8'(res_valid0),  8'd0);
        tick();                       // edge N+1: capture
        check("s1_res_valid", 8'(res_valid0),  8'd1);
        check("s1_res_data",  res_data0,       8'h08);
        check("s1_acc",       acc0,            8'h08);
        tick();                       // edge N+2: handed off
        check("s1_vld_drop",  8'(res_valid0),  8'd0);
        check("s1_ready_back", 8'(cmd_ready0), 8'd1);

        // Accumulator chaining: a=01 plus acc (08); cmd_b must be ignored
        offer(8'h01, 8'h55, OP_0, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("ch_alu_b",     alu_b0,          8'h08);
        tick();
        check("ch_res_data",  res_data0,       8'h09);
        check("ch_acc",       acc0,            8'h09);
        tick();

        // Downstream stall: 30 - 05 = 2B held for 10 cycles while another command is offered
        res_ready = 1'b0;
        offer(8'h30, 8'h05, OP_1, 1'b0);
        tick();
        offer(8'hAA, 8'h11, OP_3, 1'b0);
        tick();
        check("st_res_valid", 8'(res_valid0),  8'd1);
        check("st_res_data",  res_data0,       8'h2B);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("st_hold_valid", 8'(res_valid0), 8'd1);
            check("st_hold_data",  res_data0,      8'h2B);
            check("st_hold_acc",   acc0,           8'h2B);
            check("st_cmd_ready",  8'(cmd_ready0), 8'd0);
            check("st_alu_a",      alu_a0,         8'h30);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        check("st_vld_drop",   8'(res_valid0), 8'd0);
        check("st_ready_back", 8'(cmd_ready0), 8'd1);
        check("st_acc_kept",   acc0,           8'h2B);

        // SETTLE=3: F0 | 0F = FF captured on edge N+4, alu_f corrupted during the wait
        rst_n = 1'b0;
        #1;
        check("s3_rst_acc",   acc3,            8'h00);
        check("s3_rst_ready", 8'(cmd_ready3),  8'd1);
        tick();
        rst_n = 1'b1;
        tick();
        offer(8'hF0, 8'h0F, OP_3, 1'b0);
        tick();                       // edge N
        cmd_valid = 1'b0;
        check("s3_alu_a", alu_a3, 8'hF0);
        check("s3_alu_b", alu_b3, 8'h0F);
        for (int i = 1; i <= 3; i++) begin
            noise3 = (i == 2) ? 8'h3C : 8'hA5;
            tick();                   // edges N+1..N+3
            check("s3_wait_valid", 8'(res_valid3), 8'd0);
            check("s3_wait_busy",  8'(busy3),      8'd1);
            check("s3_wait_acc",   acc3,           8'h00);
        end
        noise3 = 8'h00;
        tick();                       // edge N+4
        check("s3_res_valid", 8'(res_valid3), 8'd1);
        check("s3_res_data",  res_data3,      8'hFF);
        check("s3_acc",       acc3,           8'hFF);
        tick();
        check("s3_vld_drop",  8'(res_valid3), 8'd0);

        // Mid-EXEC reset discards the result and clears acc
        tick();
        offer(8'h07, 8'h01, OP_0, 1'b0);
        tick();                       // accepted, now in EXEC
        cmd_valid = 1'b0;
        check("mr_in_exec", 8'(busy0), 8'd1);
        rst_n = 1'b0;
        #1;
        check("mr_res_valid", 8'(res_valid0), 8'd0);
        check("mr_acc",       acc0,           8'h00);
        check("mr_alu_a",     alu_a0,         8'h00);
        check("mr_busy",      8'(busy0),      8'd0);
        tick();
        tick();
        check("mr_still_low", 8'(res_valid0), 8'd0);
        rst_n = 1'b1;
        tick();
        offer(8'h02, 8'h06, OP_2, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mr_post_valid", 8'(res_valid0), 8'd1);
        check("mr_post_data",  res_data0,      8'h02);
        check("mr_post_acc",   acc0,           8'h02);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
